// File: rtl/cpu_pkg.sv
// Shared CPU types: register selectors, flags and the stack sequencer's command and state encodings.
package cpu_pkg;

    typedef enum logic [2:0] {
        REG_B, REG_C, REG_D, REG_E, REG_H, REG_L, REG_F, REG_A
    } register_n_t;

    typedef enum logic [2:0] {
        REG_BC, REG_DE, REG_HL, REG_AF, REG_SP, REG_PC
    } register_nn_t;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } flags_t;

    typedef enum logic [1:0] {
        OP_PUSH, OP_POP, OP_CALL, OP_RET
    } stack_op_t;

    typedef enum logic [1:0] {
        SR_BC, SR_DE, SR_HL, SR_AF
    } stack_reg_t;

    typedef enum logic [3:0] {
        ST_IDLE, ST_LD_SP, ST_LD_SRC, ST_MW_HI, ST_MW_LO, ST_MR_LO,
        ST_MR_HI, ST_WB_A, ST_WB_F, ST_WB_DST, ST_WB_SP, ST_WB_PC
    } stack_state_t;

    function automatic register_nn_t pair_of(input stack_reg_t r);
        case (r)
            SR_BC:   return REG_BC;
            SR_DE:   return REG_DE;
            SR_HL:   return REG_HL;
            default: return REG_AF;
        endcase
    endfunction

endpackage

// File: rtl/stack_engine.sv
// SM83 PUSH/POP/CALL/RET sequencer: walks SP through a byte-wide memory port and
// writes results back through the register file ports.
module stack_engine
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  stack_op_t    cmd_op,
    input  stack_reg_t   cmd_reg,
    input  logic [15:0]  cmd_target,
    output logic         done,
    output logic         rf_read_rr,
    output register_nn_t rf_read_reg_rr,
    input  logic [15:0]  rf_data_rr,
    input  logic [7:0]   rf_a,
    input  flags_t       rf_flags,
    output logic         rf_write_rr,
    output register_nn_t rf_write_reg_rr,
    output logic [15:0]  rf_data_in_rr,
    output logic         rf_write_r,
    output register_n_t  rf_write_reg_r,
    output logic [7:0]   rf_data_in_r,
    output logic         mem_req,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    output logic [7:0]   mem_wdata,
    input  logic [7:0]   mem_rdata,
    input  logic         mem_ack
);

    stack_state_t state;
    stack_op_t    op_q;
    stack_reg_t   reg_q;
    logic [15:0]  target_q;
    logic [15:0]  sp_q;
    logic [15:0]  data_q;

    logic push_like;
    logic pop_af;

    assign push_like = (op_q == OP_PUSH) || (op_q == OP_CALL);
    assign pop_af    = (op_q == OP_POP) && (reg_q == SR_AF);
    assign cmd_ready = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (cmd_valid) state <= ST_LD_SP;
                ST_LD_SP:  state <= push_like ? ST_LD_SRC : ST_MR_LO;
                ST_LD_SRC: state <= ST_MW_HI;
                ST_MW_HI:  if (mem_ack) state <= ST_MW_LO;
                ST_MW_LO:  if (mem_ack) state <= ST_WB_SP;
                ST_MR_LO:  if (mem_ack) state <= ST_MR_HI;
                ST_MR_HI:  if (mem_ack) state <= pop_af ? ST_WB_A : ST_WB_DST;
                ST_WB_A:   state <= ST_WB_F;
                ST_WB_F:   state <= ST_WB_SP;
                ST_WB_DST: state <= ST_WB_SP;
                ST_WB_SP:  state <= (op_q == OP_CALL) ? ST_WB_PC : ST_IDLE;
                ST_WB_PC:  state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Datapath latches are qualified by state, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && cmd_valid) begin
            op_q     <= cmd_op;
            reg_q    <= cmd_reg;
            target_q <= cmd_target;
        end
        if (state == ST_LD_SP)
            sp_q <= rf_data_rr;
        if (state == ST_LD_SRC)
            data_q <= (op_q == OP_PUSH && reg_q == SR_AF) ? {rf_a, rf_flags, 4'h0} : rf_data_rr;
        if (state == ST_MR_LO && mem_ack)
            data_q[7:0] <= mem_rdata;
        if (state == ST_MR_HI && mem_ack)
            data_q[15:8] <= mem_rdata;
    end

    always_comb begin
        done            = 1'b0;
        rf_read_rr      = 1'b0;
        rf_read_reg_rr  = REG_BC;
        rf_write_rr     = 1'b0;
        rf_write_reg_rr = REG_BC;
        rf_data_in_rr   = 16'h0000;
        rf_write_r      = 1'b0;
        rf_write_reg_r  = REG_B;
        rf_data_in_r    = 8'h00;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = 16'h0000;
        mem_wdata       = 8'h00;
        case (state)
            ST_LD_SP: begin
                rf_read_rr     = 1'b1;
                rf_read_reg_rr = REG_SP;
            end
            ST_LD_SRC: begin
                rf_read_rr     = 1'b1;
                rf_read_reg_rr = (op_q == OP_CALL) ? REG_PC : pair_of(reg_q);
            end
            ST_MW_HI: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_q - 16'd1;
                mem_wdata = data_q[15:8];
            end
            ST_MW_LO: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_q - 16'd2;
                mem_wdata = data_q[7:0];
            end
            ST_MR_LO: begin
                mem_req  = 1'b1;
                mem_addr = sp_q;
            end
            ST_MR_HI: begin
                mem_req  = 1'b1;
                mem_addr = sp_q + 16'd1;
            end
            ST_WB_A: begin
                rf_write_r     = 1'b1;
                rf_write_reg_r = REG_A;
                rf_data_in_r   = data_q[15:8];
            end
            ST_WB_F: begin
                rf_write_r     = 1'b1;
                rf_write_reg_r = REG_F;
                rf_data_in_r   = {data_q[7:4], 4'h0};
            end
            ST_WB_DST: begin
                rf_write_rr     = 1'b1;
                rf_write_reg_rr = (op_q == OP_RET) ? REG_PC : pair_of(reg_q);
                rf_data_in_rr   = data_q;
            end
            ST_WB_SP: begin
                rf_write_rr     = 1'b1;
                rf_write_reg_rr = REG_SP;
                rf_data_in_rr   = push_like ? (sp_q - 16'd2) : (sp_q + 16'd2);
                done            = (op_q != OP_CALL);
            end
            ST_WB_PC: begin
                rf_write_rr     = 1'b1;
                rf_write_reg_rr = REG_PC;
                rf_data_in_rr   = target_q;
                done            = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine: register file and memory stubs, plus a
// command-level reference model of SP, registers and stack memory.
module tb_stack_engine;
    import cpu_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    stack_op_t    cmd_op;
    stack_reg_t   cmd_reg;
    logic [15:0]  cmd_target;
    logic         done;
    logic         rf_read_rr;
    register_nn_t rf_read_reg_rr;
    logic [15:0]  rf_data_rr;
    logic [7:0]   rf_a;
    flags_t       rf_flags;
    logic         rf_write_rr;
    register_nn_t rf_write_reg_rr;
    logic [15:0]  rf_data_in_rr;
    logic         rf_write_r;
    register_n_t  rf_write_reg_r;
    logic [7:0]   rf_data_in_r;
    logic         mem_req;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [7:0]   mem_wdata;
    logic [7:0]   mem_rdata;
    logic         mem_ack;

    stack_engine dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_target(cmd_target), .done(done),
        .rf_read_rr(rf_read_rr), .rf_read_reg_rr(rf_read_reg_rr), .rf_data_rr(rf_data_rr),
        .rf_a(rf_a), .rf_flags(rf_flags),
        .rf_write_rr(rf_write_rr), .rf_write_reg_rr(rf_write_reg_rr), .rf_data_in_rr(rf_data_in_rr),
        .rf_write_r(rf_write_r), .rf_write_reg_r(rf_write_reg_r), .rf_data_in_r(rf_data_in_r),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Register file stub
    logic [15:0]  r_bc, r_de, r_hl, r_sp, r_pc;
    logic [7:0]   r_a, r_f;
    logic         poke_en;
    register_nn_t poke_sel;
    logic [15:0]  poke_val;

    assign rf_a     = r_a;
    assign rf_flags = flags_t'(r_f[7:4]);

    always_comb begin
        rf_data_rr = 16'h0000;
        case (rf_read_reg_rr)
            REG_BC:  rf_data_rr = r_bc;
            REG_DE:  rf_data_rr = r_de;
            REG_HL:  rf_data_rr = r_hl;
            REG_AF:  rf_data_rr = {r_a, r_f};
            REG_SP:  rf_data_rr = r_sp;
            REG_PC:  rf_data_rr = r_pc;
            default: rf_data_rr = 16'h0000;
        endcase
    end

    initial begin
        r_bc = 0; r_de = 0; r_hl = 0; r_sp = 0; r_pc = 0; r_a = 0; r_f = 0;
        forever begin
            @(posedge clk);
            if (rf_write_rr) begin
                case (rf_write_reg_rr)
                    REG_BC: r_bc <= rf_data_in_rr;
                    REG_DE: r_de <= rf_data_in_rr;
                    REG_HL: r_hl <= rf_data_in_rr;
                    REG_AF: begin r_a <= rf_data_in_rr[15:8]; r_f <= rf_data_in_rr[7:0]; end
                    REG_SP: r_sp <= rf_data_in_rr;
                    REG_PC: r_pc <= rf_data_in_rr;
                    default: ;
                endcase
            end
            if (rf_write_r) begin
                case (rf_write_reg_r)
                    REG_A: r_a <= rf_data_in_r;
                    REG_F: r_f <= rf_data_in_r;
                    REG_B: r_bc[15:8] <= rf_data_in_r;
                    REG_C: r_bc[7:0]  <= rf_data_in_r;
                    REG_D: r_de[15:8] <= rf_data_in_r;
                    REG_E: r_de[7:0]  <= rf_data_in_r;
                    REG_H: r_hl[15:8] <= rf_data_in_r;
                    REG_L: r_hl[7:0]  <= rf_data_in_r;
                    default: ;
                endcase
            end
            if (poke_en) begin
                case (poke_sel)
                    REG_BC: r_bc <= poke_val;
                    REG_DE: r_de <= poke_val;
                    REG_HL: r_hl <= poke_val;
                    REG_AF: begin r_a <= poke_val[15:8]; r_f <= poke_val[7:0]; end
                    REG_SP: r_sp <= poke_val;
                    REG_PC: r_pc <= poke_val;
                    default: ;
                endcase
            end
        end
    end

    // Memory stub with programmable ack delay
    logic [7:0]  mem [0:65535];
    logic        mpoke_en;
    logic [15:0] mpoke_addr;
    logic [7:0]  mpoke_data;
    int          mem_wait = 0;
    int          wcnt;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 29) ^ (i >> 7) ^ 8'h5A);
    endfunction

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && (wcnt >= mem_wait);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 wcnt <= 0;
        else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                        wcnt <= 0;
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
            if (mpoke_en) mem[mpoke_addr] <= mpoke_data;
        end
    end

    // Reference model: architectural state after each whole command
    logic [15:0] m_bc = 0, m_de = 0, m_hl = 0, m_sp = 0, m_pc = 0;
    logic [7:0]  m_a = 0, m_f = 0;
    logic [7:0]  m_mem [0:65535];

    function automatic logic [15:0] word_of(input stack_reg_t r);
        case (r)
            SR_BC:   return m_bc;
            SR_DE:   return m_de;
            SR_HL:   return m_hl;
            default: return {m_a, m_f[7:4], 4'h0};
        endcase
    endfunction

    task automatic put_reg(input stack_reg_t r, input logic [15:0] v);
        case (r)
            SR_BC:   m_bc = v;
            SR_DE:   m_de = v;
            SR_HL:   m_hl = v;
            default: begin m_a = v[15:8]; m_f = {v[7:4], 4'h0}; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke_rr(input register_nn_t sel, input logic [15:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_sel = sel; poke_val = v;
        @(posedge clk);
        #1 poke_en = 1'b0;
        case (sel)
            REG_BC:  m_bc = v;
            REG_DE:  m_de = v;
            REG_HL:  m_hl = v;
            REG_AF:  begin m_a = v[15:8]; m_f = v[7:0]; end
            REG_SP:  m_sp = v;
            default: m_pc = v;
        endcase
    endtask

    task automatic poke_mem(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        mpoke_en = 1'b1; mpoke_addr = a; mpoke_data = d;
        @(posedge clk);
        #1 mpoke_en = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic check_regs();
        chk("sp", r_sp, m_sp);
        chk("pc", r_pc, m_pc);
        chk("bc", r_bc, m_bc);
        chk("de", r_de, m_de);
        chk("hl", r_hl, m_hl);
        chk("a", r_a, m_a);
        chk("f", r_f, m_f);
    endtask

    task automatic run_cmd(input stack_op_t op, input stack_reg_t r, input logic [15:0] tgt,
                           input int waits, input bit hold);
        logic [15:0] sp0, hi_a, lo_a, val;
        logic [25:0] prev;
        int lat, cyc;
        bit got, pend, pushes;
        sp0 = m_sp;
        pushes = (op == OP_PUSH) || (op == OP_CALL);
        if (pushes) begin
            hi_a = sp0 - 16'd1;
            lo_a = sp0 - 16'd2;
            val  = (op == OP_CALL) ? m_pc : word_of(r);
            m_mem[hi_a] = val[15:8];
            m_mem[lo_a] = val[7:0];
            m_sp = lo_a;
            lat  = ((op == OP_CALL) ? 6 : 5) + 2 * waits;
            if (op == OP_CALL) m_pc = tgt;
        end else begin
            lo_a = sp0;
            hi_a = sp0 + 16'd1;
            val  = {m_mem[hi_a], m_mem[lo_a]};
            m_sp = sp0 + 16'd2;
            lat  = ((op == OP_POP && r == SR_AF) ? 6 : 5) + 2 * waits;
            if (op == OP_RET) m_pc = val;
            else put_reg(r, val);
        end
        mem_wait = waits;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_reg = r; cmd_target = tgt;
        chk("ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 if (!hold) cmd_valid = 1'b0;
        cyc = 0; got = 0; pend = 0; prev = '0;
        while (!got && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (pend) chk("bus_hold", 32'({mem_req, mem_we, mem_addr, mem_wdata}), 32'(prev));
            pend = mem_req && !mem_ack;
            prev = {mem_req, mem_we, mem_addr, mem_wdata};
            if (done) got = 1;
            else chk("ready_busy", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        chk("latency", cyc, lat);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("ready_after", 32'(cmd_ready), 32'd1);
        check_regs();
        if (pushes) begin
            chk("mem_hi", mem[hi_a], m_mem[hi_a]);
            chk("mem_lo", mem[lo_a], m_mem[lo_a]);
        end
    endtask

    logic [15:0] sp_pick, sp_mid;
    bit          found;

    initial begin
        for (int i = 0; i < 65536; i++) m_mem[i] = init_byte(i);
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_PUSH; cmd_reg = SR_BC; cmd_target = 16'h0;
        poke_en = 1'b0; poke_sel = REG_BC; poke_val = 16'h0;
        mpoke_en = 1'b0; mpoke_addr = 16'h0; mpoke_data = 8'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_strobes", 32'({mem_req, mem_we, rf_read_rr, rf_write_rr, rf_write_r, done}), 32'd0);
        chk("rst_bus", 32'({mem_addr, mem_wdata}), 32'd0);
        chk("rst_wdata_rr", 32'(rf_data_in_rr), 32'd0);
        rst_n = 1'b1;

        // PUSH BC at 0xFFFE
        poke_rr(REG_BC, 16'h1234);
        poke_rr(REG_SP, 16'hFFFE);
        run_cmd(OP_PUSH, SR_BC, 16'h0, 0, 1'b0);
        chk("tp_push_hi", mem[16'hFFFD], 32'h12);
        chk("tp_push_lo", mem[16'hFFFC], 32'h34);
        chk("tp_push_sp", r_sp, 32'hFFFC);

        // POP AF with low flag nibble masked
        poke_mem(16'hFFFC, 8'hFF);
        poke_mem(16'hFFFD, 8'h80);
        run_cmd(OP_POP, SR_AF, 16'h0, 0, 1'b0);
        chk("tp_popaf_a", r_a, 32'h80);
        chk("tp_popaf_f", r_f, 32'hF0);

        // CALL 0x4000
        poke_rr(REG_PC, 16'h0150);
        poke_rr(REG_SP, 16'hD000);
        run_cmd(OP_CALL, SR_BC, 16'h4000, 0, 1'b0);
        chk("tp_call_pc", r_pc, 32'h4000);
        chk("tp_call_hi", mem[16'hCFFF], 32'h01);

        // RET across the top of memory, then PUSH across zero
        poke_rr(REG_SP, 16'hFFFF);
        poke_mem(16'hFFFF, 8'h00);
        poke_mem(16'h0000, 8'h02);
        run_cmd(OP_RET, SR_BC, 16'h0, 0, 1'b0);
        chk("tp_ret_pc", r_pc, 32'h0200);
        chk("tp_ret_sp", r_sp, 32'h0001);
        poke_rr(REG_SP, 16'h0000);
        run_cmd(OP_PUSH, SR_HL, 16'h0, 0, 1'b0);
        chk("tp_wrap_sp", r_sp, 32'hFFFE);

        // Three wait cycles per transfer with cmd_valid held
        poke_rr(REG_DE, 16'hBEEF);
        run_cmd(OP_PUSH, SR_DE, 16'h0, 3, 1'b1);

        // Reset while the low byte of a PUSH is pending
        poke_rr(REG_SP, 16'h8000);
        poke_rr(REG_DE, 16'hA55A);
        sp_mid = m_sp;
        mem_wait = 3;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_reg = SR_DE;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (mem_req && mem_we && mem_addr == sp_mid - 16'd2) found = 1;
        end
        chk("midop_reached", 32'(found), 32'd1);
        m_mem[sp_mid - 16'd1] = m_de[15:8];
        rst_n = 1'b0;
        #1;
        chk("midop_req_drop", 32'(mem_req), 32'd0);
        chk("midop_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midop_sp", r_sp, m_sp);
        chk("midop_hi_kept", mem[sp_mid - 16'd1], m_mem[sp_mid - 16'd1]);
        run_cmd(OP_POP, SR_HL, 16'h0, 0, 1'b0);

        // Randomized commands
        for (int k = 0; k < 24; k++) begin
            poke_rr(register_nn_t'(3'($urandom_range(0, 3))), 16'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       sp_pick = 16'h0000;
                    1:       sp_pick = 16'hFFFF;
                    2:       sp_pick = 16'h0001;
                    default: sp_pick = 16'($urandom);
                endcase
                poke_rr(REG_SP, sp_pick);
            end
            run_cmd(stack_op_t'(2'($urandom_range(0, 3))), stack_reg_t'(2'($urandom_range(0, 3))),
                    16'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stack_engine.md
# stack_engine

Multi-cycle sequencer that executes the SM83 stack operations PUSH rr, POP rr, CALL nn and RET. It sits between the CPU decoder and the register file, driving the register file's 16-bit read/write ports, 8-bit write port and A/flags taps, plus a single-outstanding byte-wide memory port. The decoder issues one command through a valid/ready handshake and waits for `done`.

## Interface
- No parameters; all widths are fixed by the architecture.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine idle and able to accept a command.
- `cmd_op` in `stack_op_t`: PUSH, POP, CALL or RET.
- `cmd_reg` in `stack_reg_t`: BC, DE, HL or AF; used for PUSH/POP only.
- `cmd_target` in 16: CALL destination address.
- `done` out 1: one-cycle pulse in the final cycle of a command.
- `rf_read_rr`, `rf_read_reg_rr` out 1, `register_nn_t`: 16-bit read request.
- `rf_data_rr` in 16: combinational read data.
- `rf_a`, `rf_flags` in 8, `flags_t`: live A register and Z/N/H/C flags.
- `rf_write_rr`, `rf_write_reg_rr`, `rf_data_in_rr` out 1, `register_nn_t`, 16: 16-bit write.
- `rf_write_r`, `rf_write_reg_r`, `rf_data_in_r` out 1, `register_n_t`, 8: 8-bit write (POP AF only).
- `mem_req`, `mem_we` out 1, 1: bus request and write strobe.
- `mem_addr`, `mem_wdata` out 16, 8: bus address and write data.
- `mem_rdata` in 8: read data, valid in the `mem_ack` cycle.
- `mem_ack` in 1: transfer completes at the edge where `mem_req && mem_ack`; may arrive in the same cycle the request is raised.

## Operation
- The command is accepted on the edge where `cmd_valid && cmd_ready`.
  - `cmd_op`, `cmd_reg` and `cmd_target` are latched at that edge.
  - `cmd_ready` is high only in IDLE.
- FSM states: IDLE, LD_SP, LD_SRC, MW_HI, MW_LO, MR_LO, MR_HI, WB_A, WB_F, WB_DST, WB_SP, WB_PC.
- **LD_SP:** read SP; latch `sp_q`.
- **PUSH:** LD_SP → LD_SRC → MW_HI → MW_LO → WB_SP → IDLE.
  - LD_SRC reads the source pair. For AF the word is {`rf_a`, `rf_flags`, 4'h0}.
  - MW_HI writes the high byte to SP-1.
  - MW_LO writes the low byte to SP-2.
  - WB_SP writes SP-2.
- **CALL:** as PUSH with source PC, then WB_PC writes PC = `cmd_target`.
- **POP:** LD_SP → MR_LO → MR_HI → WB_DST → WB_SP → IDLE.
  - MR_LO reads the low byte at SP.
  - MR_HI reads the high byte at SP+1.
  - WB_SP writes SP+2.
- **POP AF:** WB_DST is replaced by WB_A (8-bit write of A) followed by WB_F (8-bit write of F, bits 3:0 forced to 0).
- **RET:** as POP with destination PC.
- Memory states hold `mem_req` and all address/data outputs stable until `mem_ack`. The FSM stays in the state until then; there is no timeout.
- SP arithmetic is modulo 2^16.
  - PUSH at SP=0x0000 writes 0xFFFF, then 0xFFFE; new SP = 0xFFFE.
  - POP at SP=0xFFFF reads 0xFFFF, then 0x0000; new SP = 0x0001.
- PUSH SP / POP SP are not encodable; `stack_reg_t` excludes SP.
- `done` is high in the final write-back state: WB_SP for PUSH/POP/RET, WB_PC for CALL.
- Reset mid-command:
  - FSM returns immediately to IDLE.
  - Any bus transfer is abandoned; `mem_req` drops asynchronously.
  - Partial register writes already committed are not undone.

## Timing
- All outputs are Moore-decoded from state and latched registers, except `cmd_ready`, which equals (state == IDLE).
- Reset values:
  - all strobes (`mem_req`, `mem_we`, `rf_read_rr`, `rf_write_rr`, `rf_write_r`, `done`) = 0;
  - addresses and data = 0;
  - `cmd_ready` = 1.
- One-cycle read path: `rf_read_rr` is asserted in LD_SP/LD_SRC and `rf_data_rr` is sampled at the same edge.
- A write asserted in WB_* commits at that cycle's closing edge.
- Latency from the acceptance edge to the `done` cycle, with zero-wait memory:
  - PUSH 5 cycles;
  - POP and RET 5 cycles;
  - POP AF 6 cycles;
  - CALL 6 cycles.
  - Each memory wait cycle adds one.
- A new command may be accepted in the cycle after `done`. Back-to-back commands have no bubble beyond the IDLE cycle.

## Structure
- Add to `cpu_pkg`:
  - `stack_op_t` (2-bit: PUSH, POP, CALL, RET);
  - `stack_reg_t` (2-bit: BC, DE, HL, AF);
  - the FSM state enum `stack_state_t`.
- Reuse `register_n_t`, `register_nn_t` and `flags_t` from `cpu_pkg`.
- Single flat module. No sub-module; one FSM plus an `sp_q`/`data_q` datapath.

## Test plan
- **PUSH BC**, BC=0x1234, SP=0xFFFE, zero-wait memory → writes 0x12@0xFFFD then 0x34@0xFFFC; SP=0xFFFC; `done` 5 cycles after acceptance.
- **POP AF**, memory 0xFFFC=0xFF, 0xFFFD=0x80 → A=0x80, F=0xF0, SP=0xFFFE; `done` after 6 cycles.
- **CALL 0x4000**, PC=0x0150, SP=0xD000 → 0x01@0xCFFF, 0x50@0xCFFE; SP=0xCFFE; PC=0x4000.
- **RET wrap**, SP=0xFFFF, memory 0xFFFF=0x00, 0x0000=0x02 → PC=0x0200, SP=0x0001; PUSH at SP=0x0000 → SP=0xFFFE.
- **Wait states**: `mem_ack` delayed 3 cycles per transfer on PUSH → address/data held stable and `done` arrives after 11 cycles; `cmd_valid` held throughout → `cmd_ready` stays low until IDLE.
- **Reset mid-op**: `rst_n` asserted low during MW_LO of a PUSH → `mem_req` low immediately, `cmd_ready`=1, SP unchanged, and a subsequent POP runs normally.
